// File: rtl/vcp_bridge_pkg.sv
// Shared definitions for the vector coprocessor Wishbone command bridge.
//   - Word offsets of the 4-word register window (address bits [3:2])
//   - STATUS and CTRL bit positions
//   - Bridge FSM state encoding
package vcp_bridge_pkg;

  localparam int DATA_W = 32;

  // Word index within the window (byte offset >> 2)
  localparam logic [1:0] REG_CMD    = 2'd0;  // 0x0 W: push command
  localparam logic [1:0] REG_RSP    = 2'd1;  // 0x4 R: pop result
  localparam logic [1:0] REG_STATUS = 2'd2;  // 0x8 R: status, clears err
  localparam logic [1:0] REG_CTRL   = 2'd3;  // 0xC W: flush / irq enable

  // STATUS fields
  localparam int ST_CMD_CNT_LSB = 0;
  localparam int ST_RSP_CNT_LSB = 8;
  localparam int ST_CMD_FULL    = 16;
  localparam int ST_RSP_EMPTY   = 17;
  localparam int ST_ERR         = 18;
  localparam int ST_IRQ_EN      = 19;

  // CTRL fields
  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_ACK        = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/vcp_sync_fifo.sv
// Single-clock FIFO with flush, used for both the command and result queues.
// Ports:
//   clk, reset (synchronous, active-low)
//   i_push/i_wdata : write side; a push while full (start of cycle) is refused
//   i_pop/o_rdata  : read side; o_rdata is the current head (show-ahead)
//   i_flush        : empties the FIFO, overriding any same-cycle push/pop
//   o_full/o_empty/o_count : occupancy, count is clog2(DEPTH)+1 bits wide
// DEPTH must be a power of two so the pointers wrap naturally.
module vcp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // Both qualifiers use start-of-cycle occupancy: a pop does not make room
  // for a push in the same cycle when full.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vcp_wb_cmd_bridge.sv
// Wishbone slave front end of the vector coprocessor.
// Decodes a 4-word window at BASE_ADDR, queues commands toward the core
// (valid/ready) and queues core results for the host to read back.
// Ports:
//   clk, reset (synchronous, active-low)
//   wbs_*         : Wishbone slave (stb/cyc/we/sel/adr/dat_i, ack/dat_o)
//   cmd_valid_o/cmd_data_o/cmd_ready_i : command stream to the core
//   rsp_valid_i/rsp_data_i/rsp_ready_o : result stream from the core
//   irq_o         : result-available interrupt
// Build option: define VCP_BRIDGE_IRQ_EN to drive irq_o from
//   irq_en & result-FIFO-non-empty (registered); otherwise irq_o is 0.
module vcp_wb_cmd_bridge
  import vcp_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          CMD_DEPTH = 4,
  parameter int          RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  input  logic              cmd_ready_i,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              rsp_ready_o,
  output logic              irq_o
);

  localparam int CMD_CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CNT_W = $clog2(RSP_DEPTH) + 1;

  bridge_state_t       r_state;
  bridge_state_t       w_state_next;
  logic [DATA_W-1:0]   r_dat;
  logic [DATA_W-1:0]   w_dat_next;
  logic                r_err;
  logic                r_irq_en;

  logic                w_hit, w_req;
  logic [1:0]          w_off;
  logic                w_cmd_push, w_rsp_pop, w_flush;
  logic                w_set_err, w_clr_err, w_irq_en_wr;
  logic                w_cmd_full, w_cmd_empty, w_rsp_full, w_rsp_empty;
  logic [CMD_CNT_W-1:0] w_cmd_count;
  logic [RSP_CNT_W-1:0] w_rsp_count;
  logic [DATA_W-1:0]   w_rsp_head;
  logic [DATA_W-1:0]   w_status;
  logic                w_unused_adr;

  assign w_hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_req        = wbs_stb_i & wbs_cyc_i & w_hit;
  assign w_off        = wbs_adr_i[3:2];
  assign w_unused_adr = ^wbs_adr_i[1:0];

  vcp_sync_fifo #(.WIDTH(DATA_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset),
    .i_push(w_cmd_push), .i_wdata(wbs_dat_i),
    .i_pop(cmd_ready_i), .i_flush(w_flush),
    .o_rdata(cmd_data_o), .o_full(w_cmd_full), .o_empty(w_cmd_empty),
    .o_count(w_cmd_count)
  );

  vcp_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .reset(reset),
    .i_push(rsp_valid_i), .i_wdata(rsp_data_i),
    .i_pop(w_rsp_pop), .i_flush(w_flush),
    .o_rdata(w_rsp_head), .o_full(w_rsp_full), .o_empty(w_rsp_empty),
    .o_count(w_rsp_count)
  );

  assign cmd_valid_o = ~w_cmd_empty;
  assign rsp_ready_o = ~w_rsp_full;
  assign wbs_ack_o   = (r_state == S_ACK);
  assign wbs_dat_o   = r_dat;

  always_comb begin
    w_status = '0;
    w_status[ST_CMD_CNT_LSB +: 8] = 8'(w_cmd_count);
    w_status[ST_RSP_CNT_LSB +: 8] = 8'(w_rsp_count);
    w_status[ST_CMD_FULL]         = w_cmd_full;
    w_status[ST_RSP_EMPTY]        = w_rsp_empty;
    w_status[ST_ERR]              = r_err;
    w_status[ST_IRQ_EN]           = r_irq_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Read data is recomputed every cycle, so wbs_dat_o is only non-zero
  // during the ACK cycle of a read that returns data.
  always_comb begin
    w_state_next = r_state;
    w_dat_next   = '0;
    w_cmd_push   = 1'b0;
    w_rsp_pop    = 1'b0;
    w_flush      = 1'b0;
    w_set_err    = 1'b0;
    w_clr_err    = 1'b0;
    w_irq_en_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_next = S_ACK;
          if (wbs_we_i) begin
            case (w_off)
              REG_CMD: begin
                if (wbs_sel_i != 4'hF)  w_set_err    = 1'b1;
                else if (w_cmd_full)    w_state_next = S_WAIT_SPACE;
                else                    w_cmd_push   = 1'b1;
              end
              REG_CTRL: begin
                w_flush     = wbs_dat_i[CTRL_FLUSH];
                w_irq_en_wr = 1'b1;
              end
              default: ;
            endcase
          end else begin
            case (w_off)
              REG_RSP: begin
                if (w_rsp_empty) begin
                  w_set_err = 1'b1;
                end else begin
                  w_rsp_pop  = 1'b1;
                  w_dat_next = w_rsp_head;
                end
              end
              REG_STATUS: begin
                w_dat_next = w_status;
                w_clr_err  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      S_WAIT_SPACE: begin
        // Master abandoning the cycle cancels the held write.
        if (!wbs_cyc_i) begin
          w_state_next = S_IDLE;
        end else if (!w_cmd_full) begin
          w_cmd_push   = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dat    <= '0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_dat <= w_dat_next;
      if (w_set_err)      r_err <= 1'b1;
      else if (w_clr_err) r_err <= 1'b0;
      if (w_irq_en_wr) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
  end

`ifdef VCP_BRIDGE_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= r_irq_en & ~w_rsp_empty;
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_vcp_wb_cmd_bridge.sv
// Directed self-checking bench for vcp_wb_cmd_bridge.
// Define VCP_BRIDGE_IRQ_EN for both RTL and bench to exercise the interrupt.
module tb_vcp_wb_cmd_bridge;

  localparam logic [31:0] A_CMD  = 32'h3000_0000;
  localparam logic [31:0] A_RSP  = 32'h3000_0004;
  localparam logic [31:0] A_STAT = 32'h3000_0008;
  localparam logic [31:0] A_CTRL = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_data_o;
  logic        cmd_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        rsp_ready_o;
  logic        irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vcp_wb_cmd_bridge dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o), .cmd_ready_i(cmd_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_ready_o(rsp_ready_o),
    .irq_o(irq_o)
  );

  task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
  endtask

  // Waits up to budget edges for ack; n is the number of edges consumed.
  task automatic wb_wait(input int budget, output logic got, output logic [31:0] rdata,
                         output int n);
    got = 1'b0; rdata = '0; n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      n = i + 1;
      if (wbs_ack_o) begin
        got = 1'b1; rdata = wbs_dat_o;
        break;
      end
    end
  endtask

  task automatic wb_end();
    @(negedge clk);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0;   wbs_dat_i = '0;   wbs_sel_i = '0;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic got, output logic [31:0] rdata);
    int n;
    wb_start(we, adr, dat, sel);
    wb_wait(4, got, rdata, n);
    wb_end();
    $display("[TB] %s adr=%08h wdat=%08h sel=%h ack=%0b rdat=%08h",
             we ? "WR" : "RD", adr, dat, sel, got, rdata);
  endtask

  task automatic fill_cmd(input logic [31:0] base);
    logic got; logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, A_CMD, base + 32'(i), 4'hF, got, rd);
      n_tests++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL fill_ack[%0d]: ack %0b expected 1", i, got); end
    end
  endtask

  task automatic test_reset();
    logic got; logic [31:0] rd;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({wbs_ack_o, wbs_dat_o, cmd_valid_o, rsp_ready_o, irq_o} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%0b dat=%08h cvalid=%0b rready=%0b irq=%0b expected 0/0/0/1/0",
               wbs_ack_o, wbs_dat_o, cmd_valid_o, rsp_ready_o, irq_o);
    end
    @(negedge clk) reset = 1'b1;
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL reset_status: got %08h expected 00020000", rd); end
  endtask

  task automatic test_cmd_single();
    logic got; logic [31:0] rd; int n;
    cmd_ready_i = 1'b1;
    wb_start(1'b1, A_CMD, 32'h1234_5678, 4'hF);
    wb_wait(4, got, rd, n);
    wb_end();
    $display("[TB] WR adr=%08h wdat=12345678 sel=f ack=%0b edges=%0d", A_CMD, got, n);
    n_tests++;
    if (got !== 1'b1 || n != 1) begin n_fail++; $display("FAIL cmd_latency: ack=%0b edges=%0d expected 1/1", got, n); end
    n_tests++;
    if (cmd_valid_o !== 1'b1 || cmd_data_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL cmd_out: valid=%0b data=%08h expected 1/12345678", cmd_valid_o, cmd_data_o);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL cmd_pulse: valid=%0b expected 0", cmd_valid_o); end
    cmd_ready_i = 1'b0;
  endtask

  task automatic test_wait_space();
    logic got; logic [31:0] rd; int n;
    cmd_ready_i = 1'b0;
    fill_cmd(32'h100);
    wb_start(1'b1, A_CMD, 32'h104, 4'hF);
    wb_wait(4, got, rd, n);
    n_tests++;
    if (got !== 1'b0) begin n_fail++; $display("FAIL wait_held: ack %0b expected 0", got); end
    @(negedge clk) cmd_ready_i = 1'b1;
    @(negedge clk) cmd_ready_i = 1'b0;
    wb_wait(4, got, rd, n);
    wb_end();
    $display("[TB] WR adr=%08h wdat=00000104 sel=f ack=%0b (after space)", A_CMD, got);
    n_tests++;
    if (got !== 1'b1 || n != 1) begin n_fail++; $display("FAIL wait_release: ack=%0b edges=%0d expected 1/1", got, n); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0003_0004) begin n_fail++; $display("FAIL wait_status: got %08h expected 00030004", rd); end
    cmd_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (cmd_data_o !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL drain[%0d]: got %08h expected %08h", i, cmd_data_o, 32'h100 + 32'(i));
      end
      @(negedge clk);
    end
    cmd_ready_i = 1'b0;
    n_tests++;
    if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: valid=%0b expected 0", cmd_valid_o); end
  endtask

  task automatic test_rsp();
    logic got; logic [31:0] rd;
    @(negedge clk); rsp_valid_i = 1'b1; rsp_data_i = 32'hA5A5_0001;
    @(negedge clk); rsp_data_i = 32'hA5A5_0002;
    @(negedge clk); rsp_valid_i = 1'b0; rsp_data_i = '0;
    wb_xfer(1'b0, A_RSP, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b1 || rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rsp_first: got %08h expected a5a50001", rd); end
    wb_xfer(1'b0, A_RSP, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b1 || rd !== 32'hA5A5_0002) begin n_fail++; $display("FAIL rsp_second: got %08h expected a5a50002", rd); end
    wb_xfer(1'b0, A_RSP, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL rsp_empty_read: ack=%0b got %08h expected 1/0", got, rd); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0006_0000) begin n_fail++; $display("FAIL rsp_err_set: got %08h expected 00060000", rd); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL rsp_err_clear: got %08h expected 00020000", rd); end
  endtask

  task automatic test_partial_sel();
    logic got; logic [31:0] rd;
    wb_xfer(1'b1, A_CMD, 32'hDEAD_BEEF, 4'h3, got, rd);
    n_tests++;
    if (got !== 1'b1 || cmd_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL sel_ack: ack=%0b cvalid=%0b expected 1/0", got, cmd_valid_o);
    end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0006_0000) begin n_fail++; $display("FAIL sel_err: got %08h expected 00060000", rd); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL sel_err_clear: got %08h expected 00020000", rd); end
  endtask

  task automatic test_map();
    logic got; logic [31:0] rd;
    wb_xfer(1'b0, A_CMD, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL map_rd_cmd: ack=%0b got %08h expected 1/0", got, rd); end
    wb_xfer(1'b1, A_STAT, 32'hFFFF_FFFF, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL map_wr_status: ack %0b expected 1", got); end
    wb_xfer(1'b1, 32'h3000_0010, 32'h55, 4'hF, got, rd);
    n_tests++;
    if (got !== 1'b0 || cmd_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL map_miss: ack=%0b cvalid=%0b expected 0/0", got, cmd_valid_o);
    end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL map_status: got %08h expected 00020000", rd); end
  endtask

  task automatic test_flush();
    logic got; logic [31:0] rd;
    cmd_ready_i = 1'b0;
    fill_cmd(32'h200);
    @(negedge clk); rsp_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp_data_i = 32'h300 + 32'(i);
      @(negedge clk);
    end
    rsp_valid_i = 1'b0;
    n_tests++;
    if (rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_rsp_full: rready=%0b expected 0", rsp_ready_o); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0001_0404) begin n_fail++; $display("FAIL flush_before: got %08h expected 00010404", rd); end
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, got, rd);
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000 || cmd_valid_o !== 1'b0 || rsp_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: status %08h cvalid=%0b rready=%0b expected 00020000/0/1",
                         rd, cmd_valid_o, rsp_ready_o);
    end
  endtask

  task automatic test_irq();
    logic got; logic [31:0] rd; logic exp_irq;
`ifdef VCP_BRIDGE_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    wb_xfer(1'b1, A_CTRL, 32'h2, 4'hF, got, rd);
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h000A_0000) begin n_fail++; $display("FAIL irq_en_status: got %08h expected 000a0000", rd); end
    @(negedge clk); rsp_valid_i = 1'b1; rsp_data_i = 32'h77;
    @(negedge clk); rsp_valid_i = 1'b0; rsp_data_i = '0;
    @(posedge clk); #1;
    n_tests++;
    if (irq_o !== exp_irq) begin n_fail++; $display("FAIL irq_assert: irq=%0b expected %0b", irq_o, exp_irq); end
    wb_xfer(1'b0, A_RSP, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h77) begin n_fail++; $display("FAIL irq_rsp_data: got %08h expected 00000077", rd); end
    @(posedge clk); #1;
    n_tests++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: irq=%0b expected 0", irq_o); end
    wb_xfer(1'b1, A_CTRL, 32'h0, 4'hF, got, rd);
  endtask

  task automatic test_cyc_drop();
    logic got; logic [31:0] rd; int n;
    fill_cmd(32'h400);
    wb_start(1'b1, A_CMD, 32'h404, 4'hF);
    wb_wait(3, got, rd, n);
    @(negedge clk); wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk) cmd_ready_i = 1'b1;
    @(negedge clk) cmd_ready_i = 1'b0;
    wb_wait(3, got, rd, n);
    wb_end();
    n_tests++;
    if (got !== 1'b0) begin n_fail++; $display("FAIL cyc_drop_ack: ack %0b expected 0", got); end
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0003) begin n_fail++; $display("FAIL cyc_drop_count: got %08h expected 00020003", rd); end
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, got, rd);
  endtask

  task automatic test_reset_mid();
    logic got; logic [31:0] rd; int n;
    fill_cmd(32'h500);
    wb_xfer(1'b1, A_CTRL, 32'h2, 4'hF, got, rd);
    wb_start(1'b1, A_CMD, 32'h504, 4'hF);
    wb_wait(3, got, rd, n);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({got, wbs_ack_o, cmd_valid_o, rsp_ready_o, wbs_dat_o} !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL reset_mid: held_ack=%0b ack=%0b cvalid=%0b rready=%0b dat=%08h expected 0/0/0/1/0",
                         got, wbs_ack_o, cmd_valid_o, rsp_ready_o, wbs_dat_o);
    end
    wb_end();
    reset = 1'b1;
    wb_xfer(1'b0, A_STAT, 32'h0, 4'hF, got, rd);
    n_tests++;
    if (rd !== 32'h0002_0000) begin n_fail++; $display("FAIL reset_mid_status: got %08h expected 00020000", rd); end
  endtask

  initial begin
    reset = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
    test_reset();
    test_cmd_single();
    test_wait_space();
    test_rsp();
    test_partial_sel();
    test_map();
    test_flush();
    test_irq();
    test_cyc_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
